// File: rtl/bhg_fp_clk_pkg.sv
// Shared types and constants for the multi-channel fractional clock-enable generator.
package bhg_fp_clk_pkg;

    localparam int FRAC_W = 16;

    // One channel's period: integer cycles plus a fraction in 1/65536 cycle units.
    typedef struct packed {
        logic [31:0]       int_per;
        logic [FRAC_W-1:0] frac;
    } chan_cfg_t;

    // Rounded fixed-point period in_hz/out_hz, split into integer and fraction.
    function automatic chan_cfg_t calc_default(input longint unsigned in_hz,
                                               input longint unsigned out_hz);
        longint unsigned def;
        chan_cfg_t       c;
        def       = ((in_hz << FRAC_W) + (out_hz >> 1)) / out_hz;
        c.int_per = def[FRAC_W+31:FRAC_W];
        c.frac    = def[FRAC_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/bhg_fp_clk_chan.sv
// One fractional clock channel: shadow/active period, counter, phase accumulator
// and registered clock/pulse outputs.
module bhg_fp_clk_chan
    import bhg_fp_clk_pkg::*;
#(
    parameter int                INT_W    = 24,
    parameter logic [INT_W-1:0]  DEF_INT  = INT_W'(28),
    parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic              wr_i,
    input  logic [INT_W-1:0]  wr_int_i,
    input  logic [FRAC_W-1:0] wr_frac_i,
    output logic              pending_o,
    output logic              clk_out_o,
    output logic              p0_o,
    output logic              p180_o
);

    logic [INT_W-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              cy_q, cy_d;
    logic              pend_q, pend_d;
    logic              en_q, en_d;
    logic              out_q, out_d;
    logic              p0_q, p0_d;
    logic              p180_q, p180_d;

    logic [INT_W:0]    len;
    logic              wrap;
    logic              restart;
    logic              boundary;

    // The fractional carry stretches the low phase: the half point is fixed at INT>>1.
    assign len      = {1'b0, act_int_q} + {{INT_W{1'b0}}, cy_q};
    assign wrap     = ({1'b0, cnt_q} + (INT_W+1)'(1)) == len;
    assign restart  = en_i && (sync_i || !en_q);
    assign boundary = !en_i || restart || wrap;

    // Next-state: shadow handling, period counting and output pulse generation.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        cy_d       = cy_q;
        out_d      = out_q;
        p0_d       = 1'b0;
        p180_d     = 1'b0;
        en_d       = en_i;

        // A shadow already pending is applied at this boundary; a write arriving on
        // the same edge only re-arms pending and waits for the next boundary.
        if (boundary && pend_q) begin
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            pend_d     = 1'b0;
        end
        if (wr_i) begin
            sh_int_d  = wr_int_i;
            sh_frac_d = wr_frac_i;
            pend_d    = 1'b1;
        end

        if (!en_i) begin
            cnt_d = '0;
            acc_d = '0;
            cy_d  = 1'b0;
            out_d = 1'b0;
        end else if (restart) begin
            cnt_d = '0;
            acc_d = '0;
            cy_d  = 1'b0;
            out_d = 1'b1;
            p0_d  = 1'b1;
        end else if (wrap) begin
            cnt_d         = '0;
            {cy_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
            out_d         = 1'b1;
            p0_d          = 1'b1;
        end else begin
            cnt_d = cnt_q + INT_W'(1);
            if (cnt_d == {1'b0, act_int_q[INT_W-1:1]}) begin
                out_d  = 1'b0;
                p180_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset to the elaborated default period.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            act_int_q  <= DEF_INT;
            act_frac_q <= DEF_FRAC;
            sh_int_q   <= DEF_INT;
            sh_frac_q  <= DEF_FRAC;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            cy_q       <= 1'b0;
            en_q       <= 1'b0;
            out_q      <= 1'b0;
            p0_q       <= 1'b0;
            p180_q     <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            cy_q       <= cy_d;
            en_q       <= en_d;
            out_q      <= out_d;
            p0_q       <= p0_d;
            p180_q     <= p180_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_out_o = out_q;
    assign p0_o      = p0_q;
    assign p180_o    = p180_q;

endmodule

// File: rtl/bhg_fp_clk_gen_multi.sv
// Multi-channel fractional clock-enable generator: config write decode, range
// check, error pulse and one bhg_fp_clk_chan per channel.
module bhg_fp_clk_gen_multi
    import bhg_fp_clk_pkg::*;
#(
    parameter int              NUM_CH        = 4,
    parameter int              INT_W         = 24,
    parameter longint unsigned INPUT_CLK_HZ  = 100000000,
    parameter longint unsigned OUTPUT_CLK_HZ = 3579545,
    localparam int             CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_in,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_p0,
    output logic [NUM_CH-1:0] clk_p180
);

    localparam chan_cfg_t         DEF_CFG  = calc_default(INPUT_CLK_HZ, OUTPUT_CLK_HZ);
    localparam logic [INT_W-1:0]  DEF_INT  = DEF_CFG.int_per[INT_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_CFG.frac;

    // An output faster than half the input clock cannot be represented.
    if (OUTPUT_CLK_HZ * 2 > INPUT_CLK_HZ) begin : g_bad_freq
        $error("OUTPUT_CLK_HZ must not exceed INPUT_CLK_HZ/2");
    end

    logic cfg_ok;
    logic cfg_err_q, cfg_err_d;

    // A write is legal when the period is at least 2 and the channel exists.
    assign cfg_ok    = (|cfg_int[INT_W-1:1]) && (int'(cfg_ch) < NUM_CH);
    assign cfg_err_d = cfg_wr && !cfg_ok;

    // One-cycle error pulse for a rejected write.
    always_ff @(posedge clk_in) begin
        if (rst_in) cfg_err_q <= 1'b0;
        else        cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        bhg_fp_clk_chan #(
            .INT_W    (INT_W),
            .DEF_INT  (DEF_INT),
            .DEF_FRAC (DEF_FRAC)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .en_i      (ch_en[i]),
            .sync_i    (sync_in),
            .wr_i      (cfg_wr && cfg_ok && (cfg_ch == CH_W'(i))),
            .wr_int_i  (cfg_int),
            .wr_frac_i (cfg_frac),
            .pending_o (cfg_pending[i]),
            .clk_out_o (clk_out[i]),
            .p0_o      (clk_p0[i]),
            .p180_o    (clk_p180[i])
        );
    end

endmodule

// File: tb/tb_bhg_fp_clk_gen_multi.sv
// Directed bench for bhg_fp_clk_gen_multi with three channels, so cfg_ch=3 is out of range.
module tb_bhg_fp_clk_gen_multi;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [2:0]  ch_en;
    logic        sync_in;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_int;
    logic [15:0] cfg_frac;
    logic [2:0]  cfg_pending;
    logic        cfg_err;
    logic [2:0]  clk_out;
    logic [2:0]  clk_p0;
    logic [2:0]  clk_p180;

    int n_chk = 0;
    int n_err = 0;

    bhg_fp_clk_gen_multi #(
        .NUM_CH        (3),
        .INT_W         (24),
        .INPUT_CLK_HZ  (100000000),
        .OUTPUT_CLK_HZ (3579545)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ch_en       (ch_en),
        .sync_in     (sync_in),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_int     (cfg_int),
        .cfg_frac    (cfg_frac),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .clk_out     (clk_out),
        .clk_p0      (clk_p0),
        .clk_p180    (clk_p180)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [23:0] iv, input logic [15:0] fv);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_int  = iv;
        cfg_frac = fv;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic wait_p0(input int ch, input int budget);
        int n;
        n = 0;
        while (!clk_p0[ch] && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("wait_p0 ch%0d", ch), 32'(clk_p0[ch]), 32'd1);
    endtask

    // Cycles from the current p0 to the next p0 on channel ch.
    task automatic period(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!clk_p0[ch] && n < budget);
    endtask

    initial begin
        int         times[$];
        int         n;
        int         cnt;
        logic [2:0] e;

        rst_in   = 1'b1;
        ch_en    = '0;
        sync_in  = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_int  = '0;
        cfg_frac = '0;
        step();
        step();
        rst_in = 1'b0;
        step();

        // Reset state.
        chk("rst clk_out",  32'(clk_out),     32'd0);
        chk("rst p0",       32'(clk_p0),      32'd0);
        chk("rst p180",     32'(clk_p180),    32'd0);
        chk("rst pending",  32'(cfg_pending), 32'd0);
        chk("rst err",      32'(cfg_err),     32'd0);

        // ch0 INT=4: pending while disabled is applied one cycle later.
        cfg_write(2'd0, 24'd4, 16'd0);
        chk("ch0 wr pending", 32'(cfg_pending), 32'd1);
        chk("ch0 wr no err",  32'(cfg_err),     32'd0);
        step();
        chk("ch0 applied", 32'(cfg_pending), 32'd0);
        ch_en = 3'b001;
        step();
        for (int k = 0; k < 12; k++) begin
            e = {(k % 4) < 2, (k % 4) == 0, (k % 4) == 2};
            chk($sformatf("ch0 int4 k=%0d", k),
                32'({clk_out[0], clk_p0[0], clk_p180[0]}), 32'(e));
            step();
        end

        // ch1 INT=2 FRAC=0.5: spacings 2,2,3,2,3 then 40 cycles per 16 periods.
        cfg_write(2'd1, 24'd2, 16'h8000);
        step();
        ch_en = 3'b011;
        step();
        for (int t = 0; t < 50; t++) begin
            if (clk_p0[1]) times.push_back(t);
            step();
        end
        chk("ch1 enough p0", 32'(times.size() >= 18), 32'd1);
        if (times.size() >= 18) begin
            chk("ch1 first p0", 32'(times[0]), 32'd0);
            chk("ch1 sp1", 32'(times[1] - times[0]), 32'd2);
            chk("ch1 sp2", 32'(times[2] - times[1]), 32'd2);
            chk("ch1 sp3", 32'(times[3] - times[2]), 32'd3);
            chk("ch1 sp4", 32'(times[4] - times[3]), 32'd2);
            chk("ch1 sp5", 32'(times[5] - times[4]), 32'd3);
            chk("ch1 16 periods", 32'(times[17] - times[1]), 32'd40);
        end

        // Mid-period write of INT=6 on ch0: current period stays 4.
        wait_p0(0, 20);
        step();
        cfg_write(2'd0, 24'd6, 16'd0);
        chk("ch0 int6 pending a", 32'(cfg_pending), 32'd1);
        step();
        chk("ch0 int6 pending b", 32'(cfg_pending), 32'd1);
        step();
        chk("ch0 old period p0", 32'(clk_p0[0]), 32'd1);
        chk("ch0 int6 applied",  32'(cfg_pending), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            e = {(k < 3) || (k == 6), k == 6, k == 3};
            chk($sformatf("ch0 int6 k=%0d", k),
                32'({clk_out[0], clk_p0[0], clk_p180[0]}), 32'(e));
        end

        // Rejected writes: INT=1 to ch2 and a write to channel 3.
        cfg_write(2'd2, 24'd1, 16'd0);
        chk("err int1 pulse",   32'(cfg_err),     32'd1);
        chk("err int1 pending", 32'(cfg_pending), 32'd0);
        step();
        chk("err int1 clear", 32'(cfg_err), 32'd0);
        cfg_write(2'd3, 24'd5, 16'd0);
        chk("err ch3 pulse",   32'(cfg_err),     32'd1);
        chk("err ch3 pending", 32'(cfg_pending), 32'd0);
        step();
        chk("err ch3 clear", 32'(cfg_err), 32'd0);
        ch_en = 3'b111;
        step();
        chk("ch2 enable p0", 32'(clk_p0[2]), 32'd1);
        period(2, 60, n);
        chk("ch2 default period", 32'(n), 32'd27);

        // Sync: INT 5/7/9 aligned; a write on the sync edge waits for the next wrap.
        cfg_write(2'd0, 24'd5, 16'd0);
        cfg_write(2'd1, 24'd7, 16'd0);
        cfg_write(2'd2, 24'd9, 16'd0);
        repeat (30) step();
        sync_in  = 1'b1;
        cfg_wr   = 1'b1;
        cfg_ch   = 2'd0;
        cfg_int  = 24'd3;
        cfg_frac = 16'd0;
        step();
        sync_in = 1'b0;
        cfg_wr  = 1'b0;
        chk("sync p0 all",      32'(clk_p0),      32'd7);
        chk("sync clk_out all", 32'(clk_out),     32'd7);
        chk("sync wr pending",  32'(cfg_pending), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            step();
            e = {k == 9, k == 7, (k == 5) || (k == 8)};
            chk($sformatf("sync p0 k=%0d", k), 32'(clk_p0), 32'(e));
        end
        chk("sync wr applied", 32'(cfg_pending), 32'd0);
        wait_p0(0, 20);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk("sync after p0", 32'(clk_p0), 32'd7);

        // Reset mid-period with a write pending, then measure the default period.
        cfg_write(2'd1, 24'd10, 16'd0);
        chk("pre-rst pending", 32'(cfg_pending), 32'd2);
        step();
        rst_in = 1'b1;
        ch_en  = 3'b000;
        step();
        rst_in = 1'b0;
        chk("rst2 clk_out", 32'(clk_out),     32'd0);
        chk("rst2 p0",      32'(clk_p0),      32'd0);
        chk("rst2 p180",    32'(clk_p180),    32'd0);
        chk("rst2 pending", 32'(cfg_pending), 32'd0);
        ch_en = 3'b001;
        step();
        chk("rst2 enable p0", 32'(clk_p0[0]), 32'd1);
        n   = 0;
        cnt = 0;
        while (cnt < 100 && n < 4000) begin
            step();
            n++;
            if (clk_p0[0]) cnt++;
        end
        chk("default 100 periods seen", 32'(cnt), 32'd100);
        chk($sformatf("default 100 periods n=%0d within 2793+-1", n),
            32'((n >= 2792) && (n <= 2794)), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bhg_fp_clk_gen_multi.md
# bhg_fp_clk_gen_multi

Multi-channel fractional clock-enable generator. It derives NUM_CH independent, runtime-programmable reference clocks from one system clock, such as PSG, UART baud and timer ticks. Each channel's period is INT + FRAC/65536 input cycles. New periods are programmed through a shadow-register write port and take effect glitch-free at a period boundary. All channels can be phase-aligned with a single sync strobe.

## Interface
- NUM_CH, 4: number of channels, 1..16.
- INT_W, 24: width of the integer period field.
- INPUT_CLK_HZ, 100000000: system clock frequency, used only for reset defaults.
- OUTPUT_CLK_HZ, 3579545: reset-default output frequency for every channel. Elaboration fails if OUTPUT_CLK_HZ*2 > INPUT_CLK_HZ.
- clk_in  in  1  system clock. One clock; reset is synchronous and active-high.
- rst_in  in  1  synchronous active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_in  in  1  one-cycle strobe that restarts all enabled channels in phase.
- cfg_wr  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_int  in  INT_W  integer period. Legal range is 2..2^INT_W-1.
- cfg_frac  in  16  fractional period, in units of 1/65536 cycle.
- cfg_pending  out  NUM_CH  shadow written but not yet applied.
- cfg_err  out  1  one-cycle pulse on a rejected write.
- clk_out  out  NUM_CH  roughly 50 % duty output clock.
- clk_p0  out  NUM_CH  one-cycle pulse at the rising edge of clk_out.
- clk_p180  out  NUM_CH  one-cycle pulse at the falling edge of clk_out.

## Operation
- Per-channel state:
  - active INT/FRAC
  - shadow INT/FRAC
  - counter cnt[INT_W-1:0]
  - 16-bit accumulator acc
  - carry bit cy
- Reset:
  - active and shadow are loaded with defaults. DEF = round(INPUT_CLK_HZ*65536/OUTPUT_CLK_HZ); INT = DEF>>16, FRAC = DEF[15:0].
  - acc=0, cy=0, cnt=0.
  - All outputs are 0, including cfg_pending and cfg_err.
- Period length: len = INT + cy.
  - cnt counts 0..len-1. At wrap, cnt←0 and {cy,acc}←acc+FRAC.
  - At wrap, if cfg_pending is set, active←shadow and pending clears. The new values govern the next period.
- Registered outputs:
  - clk_p0 is high in the cycle after cnt becomes 0.
  - clk_p180 is high in the cycle after cnt becomes INT>>1, using active INT.
  - clk_out rises with clk_p0 and falls with clk_p180.
  - The extra fractional cycle always lands in the low phase.
- Disabled channel (ch_en=0):
  - cnt, acc and cy are held at 0 and all outputs are 0.
  - A pending shadow is applied immediately.
  - On the first cycle ch_en is sampled high, the channel wraps. clk_p0 is high on the next cycle.
- sync_in: every enabled channel behaves as freshly enabled on that edge.
  - acc and cy clear, cnt restarts, shadow is applied.
  - The pulse repeats even if a p0 occurred in the previous cycle.
- cfg_wr:
  - With cfg_int<2 or cfg_ch≥NUM_CH: cfg_err pulses next cycle and no state changes.
  - Otherwise the shadow is written and cfg_pending[ch] is set.
  - A second write before the boundary overwrites the shadow; last write wins.
- Simultaneous events:
  - cfg_wr on a wrap cycle or a sync_in cycle is not applied at that boundary. It waits for the next one.
  - rst_in overrides everything.
  - sync_in overrides the ordinary wrap, but acc is still cleared.

## Timing
- Config write to cfg_pending set: 1 cycle.
- Shadow to active: at the first wrap strictly after the write.
- ch_en or sync_in sampled high to clk_p0: 1 cycle.
- No combinational paths from inputs to outputs.
- Long-run average frequency error is ≤ 1/65536 of the period. Peak jitter is 1 input cycle when FRAC≠0.

## Structure
- Package bhg_fp_clk_pkg contains:
  - FRAC_W=16.
  - A constant function computing the default INT/FRAC from frequencies.
  - A packed struct chan_cfg_t {int, frac}.
- Sub-module bhg_fp_clk_chan holds one channel: counter, accumulator, shadow and active registers, and output registers.
- The top level does:
  - write decode and range check
  - cfg_err generation
  - generate-loop instantiation of the channels

## Test plan
- Reset, then program ch0 INT=4, FRAC=0 and enable it.
  - clk_p0 every 4 cycles.
  - clk_out pattern 1100 repeating.
  - clk_p180 exactly 2 cycles after each clk_p0.
- ch1 INT=2, FRAC=0x8000.
  - clk_p0 spacings 2,2,3,2,3,…
  - Exactly 40 cycles across 16 consecutive periods from enable.
- Write ch0 INT=6 mid-period.
  - cfg_pending[0]=1 until the next wrap.
  - The current period stays 4; the following period is 6 and clk_p180 lands at count 3.
- Write INT=1 to ch2, and separately write to cfg_ch=NUM_CH.
  - cfg_err pulses once per write.
  - ch2 period unchanged; cfg_pending unchanged.
- Channels with INT 5, 7 and 9 running free, then assert sync_in.
  - All three clk_p0 pulses coincide one cycle later.
  - A cfg_wr in the same cycle appears only at the next wrap.
- Assert rst_in for one cycle mid-period with a write pending.
  - All outputs are 0 next cycle.
  - cfg_pending=0.
  - After re-enable, the default period of 27.9365 cycles is measured: 2793±1 cycles over 100 periods.
